// File: rtl/sdfm_pkg.sv
// Shared definitions for the two-channel sigma-delta filter: register map, ID, CFG fields.
// No logic of its own; latency not applicable.
// No flow control; constants and a field-unpacking helper only.
package sdfm_pkg;

   localparam int IWIDTH_DEF = 26;

   localparam logic [31:0] ID_VALUE = 32'h5344_0100;

   // Register offsets within the 64-byte window
   localparam logic [5:0] OFF_ID     = 6'h00;
   localparam logic [5:0] OFF_STATUS = 6'h04;
   localparam logic [5:0] OFF_CTRL   = 6'h08;
   localparam logic [5:0] OFF_CFG0   = 6'h0C;
   localparam logic [5:0] OFF_CFG1   = 6'h10;
   localparam logic [5:0] OFF_DATA0  = 6'h14;
   localparam logic [5:0] OFF_DATA1  = 6'h18;
   localparam logic [5:0] OFF_CMP0   = 6'h24;
   localparam logic [5:0] OFF_CMP1   = 6'h28;

   // CFG word field positions
   localparam int CFG_DOSR_LSB  = 0;
   localparam int CFG_SHIFT_LSB = 12;
   localparam int CFG_ORD_LSB   = 16;
   localparam int CFG_EDGE      = 20;
   localparam int CFG_INV       = 21;
   localparam int CFG_RDY_IE    = 24;
   localparam int CFG_CMP_IE    = 25;
   localparam int CFG_OFMT      = 26;

   // Per-channel filter settings as seen by the channel datapath
   typedef struct packed {
      logic [7:0] dosr;
      logic [3:0] shift;
      logic [1:0] ord;
      logic       edge_fall;
      logic       inv;
      logic       ofmt;
   } ch_cfg_t;

   function automatic ch_cfg_t cfg_fields(input logic [31:0] w);
      ch_cfg_t c;
      c.dosr      = w[CFG_DOSR_LSB +: 8];
      c.shift     = w[CFG_SHIFT_LSB +: 4];
      c.ord       = w[CFG_ORD_LSB +: 2];
      c.edge_fall = w[CFG_EDGE];
      c.inv       = w[CFG_INV];
      c.ofmt      = w[CFG_OFMT];
      return c;
   endfunction

endpackage

// File: rtl/sdfm_channel.sv
// One SDFM channel: bitstream sync, edge sampling, sinc1..3 CIC, decimation, format, comparator.
// Latency: sample edge seen 2-3 clocks after SDCLK pin edge; data register written 1 clock after decimation.
// No backpressure: one result per decimation, smp_vld/trip_vld are single-cycle pulses.
module sdfm_channel
   import sdfm_pkg::*;
#(
   parameter int IWIDTH = IWIDTH_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  ch_cfg_t     cfg,
   input  logic [15:0] cmp_hi,
   input  logic [15:0] cmp_lo,
   input  logic        sdclk,
   input  logic        dsdin,
   output logic        smp_vld,
   output logic        trip_vld,
   output logic [31:0] smp_dat
);

   // [0],[1] synchronizer stages, [2] previous synchronized level for edge detect
   logic [2:0]               sclk_q, sclk_d;
   logic [1:0]               din_q, din_d;
   logic signed [IWIDTH-1:0] int1_q, int1_d, int2_q, int2_d, int3_q, int3_d;
   logic signed [IWIDTH-1:0] dly1_q, dly1_d, dly2_q, dly2_d, dly3_q, dly3_d;
   logic [7:0]               cnt_q, cnt_d;
   logic                     dec_q, dec_d;
   logic [31:0]              data_q, data_d;

   logic                     smp;
   logic                     bit_v;
   logic signed [IWIDTH-1:0] x;
   logic signed [IWIDTH-1:0] top, c1, c2, c3, filt;
   logic signed [31:0]       ext_s, shf_s;
   logic [15:0]              sat16;
   logic                     trip;

   // Synchronize pins and pick the configured sampling edge
   always_comb begin
      sclk_d = {sclk_q[1:0], sdclk};
      din_d  = {din_q[0], dsdin};
      smp    = cfg.edge_fall ? (~sclk_q[1] & sclk_q[2]) : (sclk_q[1] & ~sclk_q[2]);
      bit_v  = din_q[1] ^ cfg.inv;
      x      = bit_v ? {{(IWIDTH-1){1'b0}}, 1'b1} : {IWIDTH{1'b1}};
   end

   // Integrators and decimation counter advance once per sampled bit; disable clears them
   always_comb begin
      int1_d = int1_q;
      int2_d = int2_q;
      int3_d = int3_q;
      cnt_d  = cnt_q;
      dec_d  = 1'b0;
      if (!en) begin
         int1_d = '0;
         int2_d = '0;
         int3_d = '0;
         cnt_d  = '0;
      end else if (smp) begin
         int1_d = int1_q + x;
         int2_d = int2_q + int1_d;
         int3_d = int3_q + int2_d;
         // >= keeps the counter from running past a DOSR lowered mid-stream
         if (cnt_q >= cfg.dosr) begin
            cnt_d = '0;
            dec_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   // Comb stages evaluated in the cycle after decimation, against last decimation's values
   always_comb begin
      case (cfg.ord)
         2'd0:    top = int1_q;
         2'd1:    top = int2_q;
         default: top = int3_q;
      endcase
      c1 = top - dly1_q;
      c2 = c1 - dly2_q;
      c3 = c2 - dly3_q;
      case (cfg.ord)
         2'd0:    filt = c1;
         2'd1:    filt = c2;
         default: filt = c3;
      endcase
      dly1_d = dly1_q;
      dly2_d = dly2_q;
      dly3_d = dly3_q;
      if (!en) begin
         dly1_d = '0;
         dly2_d = '0;
         dly3_d = '0;
      end else if (dec_q) begin
         dly1_d = top;
         dly2_d = c1;
         dly3_d = c2;
      end
   end

   // Shift, saturate, format and compare the new sample
   always_comb begin
      ext_s = 32'(filt);
      shf_s = ext_s >>> cfg.shift;
      if (shf_s > 32'sd32767) begin
         sat16 = 16'h7FFF;
      end else if (shf_s < -32'sd32768) begin
         sat16 = 16'h8000;
      end else begin
         sat16 = shf_s[15:0];
      end
      trip   = dec_q & (($signed(sat16) > $signed(cmp_hi)) | ($signed(sat16) < $signed(cmp_lo)));
      data_d = data_q;
      if (dec_q) begin
         data_d = cfg.ofmt ? {{16{sat16[15]}}, sat16} : shf_s;
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= '0;
         din_q  <= '0;
         int1_q <= '0;
         int2_q <= '0;
         int3_q <= '0;
         dly1_q <= '0;
         dly2_q <= '0;
         dly3_q <= '0;
         cnt_q  <= '0;
         dec_q  <= 1'b0;
         data_q <= '0;
      end else begin
         sclk_q <= sclk_d;
         din_q  <= din_d;
         int1_q <= int1_d;
         int2_q <= int2_d;
         int3_q <= int3_d;
         dly1_q <= dly1_d;
         dly2_q <= dly2_d;
         dly3_q <= dly3_d;
         cnt_q  <= cnt_d;
         dec_q  <= dec_d;
         data_q <= data_d;
      end
   end

   assign smp_vld  = dec_q;
   assign trip_vld = trip;
   assign smp_dat  = data_q;

endmodule

// File: rtl/sdfm.sv
// Two-channel sigma-delta filter: host register window, STATUS flags and IRQ around two channels.
// Latency: register write 1 clock; read data combinational; IRQ 1 clock after a flag sets.
// No backpressure: bus accesses always complete, flags are set-dominant over write-1-to-clear.
module sdfm
   import sdfm_pkg::*;
#(
   parameter logic [15:0] BASE   = 16'h0700,
   parameter int          IWIDTH = IWIDTH_DEF
) (
   input  logic        EXTCLK,
   input  logic        EXTRSTn,
   input  logic [1:0]  DSDIN,
   input  logic [1:0]  SDCLK,
   input  logic        RD,
   input  logic        WR,
   input  logic [15:0] ADDR,
   inout  wire  [31:0] DATA,
   output logic        IRQ
);

   logic [31:0] ctrl_q, ctrl_d, cfg0_q, cfg0_d, cfg1_q, cfg1_d;
   logic [31:0] cmp0_q, cmp0_d, cmp1_q, cmp1_d;
   logic [3:0]  status_q, status_d;
   logic        irq_q, irq_d;

   logic        hit, wr_hit, rd_en;
   logic [5:0]  off;
   logic [31:0] rdata;
   logic [3:0]  status_set, status_clr;
   logic [1:0]  smp_vld, trip_vld;
   logic [31:0] data0, data1;
   logic        reg_unused;

   assign hit    = (ADDR[15:6] == BASE[15:6]);
   assign off    = ADDR[5:0];
   assign wr_hit = WR & hit;
   assign rd_en  = RD & ~WR & hit;

   assign DATA = rd_en ? rdata : {32{1'bz}};
   assign IRQ  = irq_q;

   // Reserved CFG/CTRL bits are stored and read back only
   assign reg_unused = ^{ctrl_q[31:2], cfg0_q[31:27], cfg0_q[23:22], cfg0_q[19:18], cfg0_q[11:8],
                         cfg1_q[31:27], cfg1_q[23:22], cfg1_q[19:18], cfg1_q[11:8]};

   sdfm_channel #(.IWIDTH(IWIDTH)) u_ch0 (
      .clk      (EXTCLK),
      .rst_n    (EXTRSTn),
      .en       (ctrl_q[0]),
      .cfg      (cfg_fields(cfg0_q)),
      .cmp_hi   (cmp0_q[31:16]),
      .cmp_lo   (cmp0_q[15:0]),
      .sdclk    (SDCLK[0]),
      .dsdin    (DSDIN[0]),
      .smp_vld  (smp_vld[0]),
      .trip_vld (trip_vld[0]),
      .smp_dat  (data0)
   );

   sdfm_channel #(.IWIDTH(IWIDTH)) u_ch1 (
      .clk      (EXTCLK),
      .rst_n    (EXTRSTn),
      .en       (ctrl_q[1]),
      .cfg      (cfg_fields(cfg1_q)),
      .cmp_hi   (cmp1_q[31:16]),
      .cmp_lo   (cmp1_q[15:0]),
      .sdclk    (SDCLK[1]),
      .dsdin    (DSDIN[1]),
      .smp_vld  (smp_vld[1]),
      .trip_vld (trip_vld[1]),
      .smp_dat  (data1)
   );

   // Read mux; unmapped offsets return zero
   always_comb begin
      rdata = '0;
      case (off)
         OFF_ID:     rdata = ID_VALUE;
         OFF_STATUS: rdata = {28'd0, status_q};
         OFF_CTRL:   rdata = ctrl_q;
         OFF_CFG0:   rdata = cfg0_q;
         OFF_CFG1:   rdata = cfg1_q;
         OFF_DATA0:  rdata = data0;
         OFF_DATA1:  rdata = data1;
         OFF_CMP0:   rdata = cmp0_q;
         OFF_CMP1:   rdata = cmp1_q;
         default:    rdata = '0;
      endcase
   end

   // Register writes, STATUS set/clear and IRQ from the current flags
   always_comb begin
      ctrl_d     = ctrl_q;
      cfg0_d     = cfg0_q;
      cfg1_d     = cfg1_q;
      cmp0_d     = cmp0_q;
      cmp1_d     = cmp1_q;
      status_clr = '0;
      if (wr_hit) begin
         case (off)
            OFF_STATUS: status_clr = DATA[3:0];
            OFF_CTRL:   ctrl_d     = DATA;
            OFF_CFG0:   cfg0_d     = DATA;
            OFF_CFG1:   cfg1_d     = DATA;
            OFF_CMP0:   cmp0_d     = DATA;
            OFF_CMP1:   cmp1_d     = DATA;
            default:    ;
         endcase
      end
      status_set = {trip_vld, smp_vld};
      status_d   = (status_q & ~status_clr) | status_set;
      irq_d      = |(status_q & {cfg1_q[CFG_CMP_IE], cfg0_q[CFG_CMP_IE],
                                 cfg1_q[CFG_RDY_IE], cfg0_q[CFG_RDY_IE]});
   end

   // Host-visible registers
   always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
      if (!EXTRSTn) begin
         ctrl_q   <= '0;
         cfg0_q   <= '0;
         cfg1_q   <= '0;
         cmp0_q   <= '0;
         cmp1_q   <= '0;
         status_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         ctrl_q   <= ctrl_d;
         cfg0_q   <= cfg0_d;
         cfg1_q   <= cfg1_d;
         cmp0_q   <= cmp0_d;
         cmp1_q   <= cmp1_d;
         status_q <= status_d;
         irq_q    <= irq_d;
      end
   end

endmodule

// File: tb/tb_sdfm.sv
// Bench for sdfm: register table, directed filter sequences, randomized CIC runs vs. a convolution model.
module tb_sdfm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  DSDIN = 2'b00;
   logic [1:0]  SDCLK = 2'b00;
   logic        RD = 1'b0;
   logic        WR = 1'b0;
   logic [15:0] ADDR = 16'h0000;
   logic        IRQ;
   logic [31:0] drv_dat = 32'h0;
   logic        drv_en = 1'b0;
   wire  [31:0] DATA_w;

   assign DATA_w = drv_en ? drv_dat : {32{1'bz}};

   always #5 clk = ~clk;

   sdfm dut (
      .EXTCLK  (clk),
      .EXTRSTn (rst_n),
      .DSDIN   (DSDIN),
      .SDCLK   (SDCLK),
      .RD      (RD),
      .WR      (WR),
      .ADDR    (ADDR),
      .DATA    (DATA_w),
      .IRQ     (IRQ)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
      @(negedge clk);
      ADDR = a; drv_dat = d; drv_en = 1'b1; WR = 1'b1;
      @(negedge clk);
      WR = 1'b0; drv_en = 1'b0;
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
      @(negedge clk);
      ADDR = a; RD = 1'b1;
      #1 d = DATA_w;
      RD = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [15:0] a, input logic [31:0] exp);
      logic [31:0] v;
      bus_rd(a, v);
      chk(nm, v, exp);
   endtask

   // One modulator bit: data changes with the non-sampling edge, sampling edge 3 clocks later
   task automatic send_bit(input int ch, input bit b, input bit edg);
      @(negedge clk);
      SDCLK[ch] = edg;
      DSDIN[ch] = b;
      repeat (3) @(negedge clk);
      SDCLK[ch] = ~edg;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_n(input int ch, input bit b, input int n);
      for (int i = 0; i < n; i++) send_bit(ch, b, 1'b0);
   endtask

   task automatic settle();
      repeat (6) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   // Filter impulse response = boxcar of length R convolved with itself ORD times;
   // output at a decimation = that response applied to the +/-1 history.
   int href[$];
   int hist[$];

   task automatic build_h(input int ordn, input int r);
      int t[$];
      href.delete();
      href.push_back(1);
      for (int s = 0; s < ordn; s++) begin
         t.delete();
         for (int i = 0; i < href.size() + r - 1; i++) begin
            int acc;
            acc = 0;
            for (int j = 0; j < r; j++)
               if (i - j >= 0 && i - j < href.size()) acc += href[i - j];
            t.push_back(acc);
         end
         href = t;
      end
   endtask

   function automatic int ref_y();
      int y;
      int n;
      y = 0;
      n = hist.size();
      for (int j = 0; j < href.size() && j < n; j++) y += href[j] * hist[n - 1 - j];
      return y;
   endfunction

   function automatic int ref_sat(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   typedef struct {
      bit          wr;
      logic [15:0] a;
      logic [31:0] d;
   } vec_t;

   vec_t vt[19];

   initial begin
      logic [31:0] v;

      vt[0]  = '{1'b1, 16'h0708, 32'h0000_0003};
      vt[1]  = '{1'b1, 16'h070C, 32'h0511_00FF};
      vt[2]  = '{1'b1, 16'h0710, 32'h0323_D0FF};
      vt[3]  = '{1'b1, 16'h0724, 32'hABCD_6894};
      vt[4]  = '{1'b1, 16'h0728, 32'h1234_53DC};
      vt[5]  = '{1'b0, 16'h0708, 32'h0000_0003};
      vt[6]  = '{1'b0, 16'h070C, 32'h0511_00FF};
      vt[7]  = '{1'b0, 16'h0710, 32'h0323_D0FF};
      vt[8]  = '{1'b0, 16'h0724, 32'hABCD_6894};
      vt[9]  = '{1'b0, 16'h0728, 32'h1234_53DC};
      vt[10] = '{1'b0, 16'h0720, 32'h0000_0000};
      vt[11] = '{1'b1, 16'h0700, 32'hFFFF_FFFF};
      vt[12] = '{1'b0, 16'h0700, 32'h5344_0100};
      vt[13] = '{1'b1, 16'h1708, 32'h0000_0000};
      vt[14] = '{1'b0, 16'h0708, 32'h0000_0003};
      vt[15] = '{1'b1, 16'h0720, 32'hFFFF_FFFF};
      vt[16] = '{1'b0, 16'h0720, 32'h0000_0000};
      vt[17] = '{1'b0, 16'h0714, 32'h0000_0000};
      vt[18] = '{1'b0, 16'h072C, 32'h0000_0000};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Reset state
      rd_chk("rst_id", 16'h0700, 32'h5344_0100);
      rd_chk("rst_ctrl", 16'h0708, 32'h0);
      rd_chk("rst_status", 16'h0704, 32'h0);
      chk("rst_irq", {31'd0, IRQ}, 32'h0);
      // With RD low the DUT must not drive: a bench-driven 0 must read back unchanged
      @(negedge clk);
      ADDR = 16'h0700; drv_dat = 32'h0; drv_en = 1'b1;
      #1 chk("hiz", DATA_w, 32'h0);
      drv_en = 1'b0;

      // Register table
      for (int i = 0; i < 19; i++) begin
         if (vt[i].wr) bus_wr(vt[i].a, vt[i].d);
         else rd_chk($sformatf("tbl%0d", i), vt[i].a, vt[i].d);
      end

      // Ch1 sinc3, DOSR=255, constant ones
      bus_wr(16'h0708, 32'h0);
      bus_wr(16'h0710, 32'h0002_00FF);
      bus_wr(16'h0728, 32'h7FFF_8000);
      bus_wr(16'h0704, 32'hF);
      bus_wr(16'h0708, 32'h2);
      send_n(1, 1'b1, 768);
      settle();
      rd_chk("sinc3_data", 16'h0718, 32'h0100_0000);
      rd_chk("sinc3_status", 16'h0704, 32'h2);
      bus_wr(16'h0704, 32'hF);
      bus_wr(16'h0710, 32'h0002_D0FF);
      send_n(1, 1'b1, 256);
      settle();
      rd_chk("sinc3_shift13", 16'h0718, 32'h0000_0800);

      // Ch0 sinc1 alternating bits, ready interrupt
      bus_wr(16'h0708, 32'h0);
      bus_wr(16'h070C, 32'h0100_00FF);
      bus_wr(16'h0724, 32'h7FFF_8000);
      bus_wr(16'h0704, 32'hF);
      bus_wr(16'h0708, 32'h1);
      for (int i = 0; i < 256; i++) send_bit(0, (i % 2) == 0, 1'b0);
      settle();
      rd_chk("alt_data", 16'h0714, 32'h0);
      rd_chk("alt_status", 16'h0704, 32'h1);
      chk("alt_irq", {31'd0, IRQ}, 32'h1);
      bus_wr(16'h0704, 32'h1);
      chk("alt_irq_clr_edge", {31'd0, IRQ}, 32'h1);
      @(negedge clk);
      chk("alt_irq_fall", {31'd0, IRQ}, 32'h0);
      rd_chk("alt_status_clr", 16'h0704, 32'h0);
      for (int i = 0; i < 256; i++) send_bit(0, (i % 2) == 1, 1'b0);
      settle();
      rd_chk("alt_data2", 16'h0714, 32'h0);
      rd_chk("alt_status2", 16'h0704, 32'h1);

      // Ch0 sinc1, 16-bit output, comparator high trip
      bus_wr(16'h0708, 32'h0);
      bus_wr(16'h070C, 32'h0600_00FF);
      bus_wr(16'h0724, 32'h00FF_FF00);
      bus_wr(16'h0704, 32'hF);
      bus_wr(16'h0708, 32'h1);
      send_n(0, 1'b1, 256);
      settle();
      rd_chk("cmp_data", 16'h0714, 32'h0000_0100);
      rd_chk("cmp_status", 16'h0704, 32'h5);
      chk("cmp_irq", {31'd0, IRQ}, 32'h1);

      // Disable mid-stream: no decimations while off, counter and integrators restart on enable
      bus_wr(16'h0704, 32'hF);
      send_n(0, 1'b1, 100);
      bus_wr(16'h0708, 32'h0);
      send_n(0, 1'b1, 300);
      settle();
      rd_chk("dis_status", 16'h0704, 32'h0);
      rd_chk("dis_data_kept", 16'h0714, 32'h0000_0100);
      bus_wr(16'h0708, 32'h1);
      send_n(0, 1'b0, 255);
      settle();
      rd_chk("reen_255", 16'h0704, 32'h0);
      send_n(0, 1'b0, 1);
      settle();
      rd_chk("reen_256", 16'h0704, 32'h1);
      rd_chk("reen_data", 16'h0714, 32'hFFFF_FF00);
      chk("reen_irq", {31'd0, IRQ}, 32'h0);

      // Randomized configurations against the convolution model
      for (int it = 0; it < 6; it++) begin
         int ch, dosr, ordv, ordn, sh, p, r, y, s;
         bit inv, edg, ofmt, rie, cie, b, trp;
         logic [15:0] hi, lo;
         logic [31:0] cfg, exp_dat;
         ch   = $urandom_range(0, 1);
         dosr = $urandom_range(3, 40);
         ordv = $urandom_range(0, 3);
         ordn = (ordv == 0) ? 1 : (ordv == 1) ? 2 : 3;
         sh   = $urandom_range(0, 6);
         inv  = 1'($urandom_range(0, 1));
         edg  = 1'($urandom_range(0, 1));
         ofmt = 1'($urandom_range(0, 1));
         rie  = 1'($urandom_range(0, 1));
         cie  = 1'($urandom_range(0, 1));
         p    = $urandom_range(5, 95);
         hi   = 16'($urandom_range(0, 400)) - 16'd100;
         lo   = hi - 16'($urandom_range(0, 500));
         r    = dosr + 1;
         cfg  = {5'd0, ofmt, cie, rie, 2'd0, inv, edg, 2'd0, 2'(ordv), 4'(sh), 4'd0, 8'(dosr)};
         bus_wr(16'h0708, 32'h0);
         bus_wr(16'h070C + 16'(4 * ch), cfg);
         bus_wr(16'h0724 + 16'(4 * ch), {hi, lo});
         bus_wr(16'h0704, 32'hF);
         bus_wr(16'h0708, 32'(1 << ch));
         hist.delete();
         build_h(ordn, r);
         for (int d = 0; d < 5; d++) begin
            for (int k = 0; k < r; k++) begin
               b = ($urandom_range(0, 99) < p);
               send_bit(ch, b, edg);
               hist.push_back((b ^ inv) ? 1 : -1);
            end
            settle();
            y = ref_y() >>> sh;
            s = ref_sat(y);
            trp = (s > int'($signed(hi))) || (s < int'($signed(lo)));
            exp_dat = ofmt ? 32'(s) : 32'(y);
            if (d >= ordn) begin
               rd_chk($sformatf("rnd%0d_d%0d_data", it, d), 16'h0714 + 16'(4 * ch), exp_dat);
               rd_chk($sformatf("rnd%0d_d%0d_status", it, d), 16'h0704,
                      32'((1 << ch) | (int'(trp) << (ch + 2))));
               chk($sformatf("rnd%0d_d%0d_irq", it, d), {31'd0, IRQ},
                   {31'd0, rie | (cie & trp)});
            end else begin
               bus_rd(16'h0704, v);
               chk($sformatf("rnd%0d_d%0d_rdy", it, d), {31'd0, v[ch]}, 32'h1);
            end
            bus_wr(16'h0704, 32'hF);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
